stopwatch_display: RTL and testbench

Downstream display stage for the stopwatch. It consumes the `minutes`, `seconds` and `status` outputs of `stopwatch_top` and converts them to BCD with a sequential double-dabble engine. It then drives a 4-digit, common-anode, multiplexed seven-segment display (MM.SS). It also flags minute values that cannot be shown in two digits.

---
 rtl/stopwatch_pkg.sv | 58 +++++
 rtl/stopwatch_display_if.sv | 19 +
 rtl/bin2bcd_serial.sv | 74 +++++++
 rtl/stopwatch_display.sv | 250 +++++++++++++++++++++++++
 tb/tb_stopwatch_display.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/stopwatch_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : stopwatch_pkg
//  Description : Shared definitions for the stopwatch display path: status
//                encodings, display digit indices and active-low
//                seven-segment patterns (bit0 = a ... bit6 = g).
//  Revision    : 1.0  initial release
// ============================================================================
package stopwatch_pkg;

    // Stopwatch state reported by stopwatch_top
    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_RUNNING = 2'b01,
        ST_PAUSED  = 2'b10
    } status_t;

    // Display digit positions, also the an_n bit index
    typedef enum logic [1:0] {
        DIG_SEC_UNITS = 2'd0,
        DIG_SEC_TENS  = 2'd1,
        DIG_MIN_UNITS = 2'd2,
        DIG_MIN_TENS  = 2'd3
    } digit_t;

    // Active-low segment patterns, {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // BCD nibble to segment pattern; codes above 9 cannot come out of the
    // converter, but are shown blank rather than as garbage if they do.
    function automatic logic [6:0] seg_encode(input logic [3:0] digit);
        case (digit)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_BLANK;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/stopwatch_display_if.sv
`default_nettype none
// ============================================================================
//  Interface   : stopwatch_display_if
//  Description : Time/status bus from stopwatch_top to stopwatch_display.
//                minutes [7:0] binary minutes 0..255
//                seconds [5:0] binary seconds 0..59
//                status  [1:0] stopwatch state (see stopwatch_pkg::status_t)
//                master = producer (stopwatch_top), slave = display stage.
//  Revision    : 1.0  initial release
// ============================================================================
interface stopwatch_display_if;
    logic [7:0] minutes;
    logic [5:0] seconds;
    logic [1:0] status;

    modport master (output minutes, output seconds, output status);
    modport slave  (input  minutes, input  seconds, input  status);
endinterface
`default_nettype wire

// File: rtl/bin2bcd_serial.sv
`default_nettype none
// ============================================================================
//  Module      : bin2bcd_serial
//  Description : Sequential double-dabble binary to BCD converter, one bit
//                per clock, MSB first. A start pulse loads 'bin' (the value
//                left-aligned in WIDTH bits) and clears the BCD register;
//                'len' is the number of bits to convert, so one instance can
//                be time-shared between operands of different widths.
//  Ports       : clk, rst_n      clock, asynchronous active-low reset
//                start           load bin/len, restart conversion
//                len             bits to convert (1..WIDTH)
//                bin             left-aligned binary operand
//                done            the coming edge performs the final shift;
//                                bcd_next then holds the finished result
//                almost_done     two shifts remain
//                bcd_next        BCD value after the current iteration
//  Revision    : 1.0  initial release
// ============================================================================
module bin2bcd_serial #(
    parameter  int WIDTH  = 8,
    localparam int DIGITS = (WIDTH + 2) / 3,
    localparam int BCD_W  = 4 * DIGITS,
    localparam int LEN_W  = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic [WIDTH-1:0] bin,
    output logic             done,
    output logic             almost_done,
    output logic [BCD_W-1:0] bcd_next
);

    logic [WIDTH-1:0] r_shift;
    logic [BCD_W-1:0] r_bcd;
    logic [LEN_W-1:0] r_rem;
    logic [BCD_W-1:0] w_adj;
    logic             w_unused_msb;

    // Add-3 correction on every nibble that would overflow after doubling
    always_comb begin
        w_adj = r_bcd;
        for (int d = 0; d < DIGITS; d++) begin
            if (r_bcd[4*d +: 4] >= 4'd5) begin
                w_adj[4*d +: 4] = r_bcd[4*d +: 4] + 4'd3;
            end
        end
    end

    // DIGITS is sized so the top bit never carries out for a WIDTH-bit input
    assign w_unused_msb = w_adj[BCD_W-1];
    assign bcd_next     = {w_adj[BCD_W-2:0], r_shift[WIDTH-1]};
    assign done         = (r_rem == LEN_W'(1));
    assign almost_done  = (r_rem == LEN_W'(2));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift <= '0;
            r_bcd   <= '0;
            r_rem   <= '0;
        end else if (start) begin
            r_shift <= bin;
            r_bcd   <= '0;
            r_rem   <= len;
        end else if (r_rem != '0) begin
            r_bcd   <= bcd_next;
            r_shift <= {r_shift[WIDTH-2:0], 1'b0};
            r_rem   <= r_rem - LEN_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/stopwatch_display.sv
`default_nettype none
// ============================================================================
//  Module      : stopwatch_display
//  Description : Display stage for the stopwatch. Snapshots minutes/seconds
//                on change, converts them to BCD with one shared serial
//                double-dabble engine, commits all digits at once and scans
//                a 4-digit common-anode seven-segment display as MM.SS.
//                Minutes >= 100 show value mod 100 and raise min_ovf.
//  Ports       : clk, rst_n      clock, asynchronous active-low reset
//                bus             stopwatch_display_if.slave (minutes,
//                                seconds, status)
//                seg_n[6:0]      active-low segments, bit0 = a
//                dp_n            active-low decimal point (MM.SS separator)
//                an_n[3:0]       active-low digit enables, bit0 = sec units
//                min_ovf         committed minutes >= 100
//  Options     : DISPLAY_BLINK_EN - blank the display every other BLINK_DIV
//                cycles while status is PAUSED. Without it status is unused.
//  Revision    : 1.0  initial release
// ============================================================================
module stopwatch_display
    import stopwatch_pkg::*;
#(
    parameter int REFRESH_DIV = 50000,
    parameter int BLINK_DIV   = 25000000
) (
    input  logic                clk,
    input  logic                rst_n,
    stopwatch_display_if.slave  bus,
    output logic [6:0]          seg_n,
    output logic                dp_n,
    output logic [3:0]          an_n,
    output logic                min_ovf
);

    localparam int MIN_W     = 8;
    localparam int SEC_W     = 6;
    localparam int CNV_LEN_W = $clog2(MIN_W + 1);
    localparam int REF_W     = $clog2(REFRESH_DIV);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD   = 3'd1;
    localparam logic [2:0] S_MIN    = 3'd2;
    localparam logic [2:0] S_SEC    = 3'd3;
    localparam logic [2:0] S_COMMIT = 3'd4;

    logic [2:0]           r_state;
    logic [2:0]           w_state_nxt;

    logic [MIN_W-1:0]     r_snap_min;
    logic [SEC_W-1:0]     r_snap_sec;
    logic [11:0]          r_min_bcd;
    logic [3:0]           r_sec_units;
    logic [3:0]           r_sec_tens;
    logic [3:0]           r_min_units;
    logic [3:0]           r_min_tens;
    logic                 r_ovf;

    logic [REF_W-1:0]     r_ref;
    logic [1:0]           r_idx;
    logic [3:0]           w_digit;
    logic                 w_blank;

    logic                 w_input_changed;
    logic                 w_cnv_start;
    logic [MIN_W-1:0]     w_cnv_bin;
    logic [CNV_LEN_W-1:0] w_cnv_len;
    logic                 w_cnv_done;
    logic                 w_cnv_almost;
    logic [11:0]          w_cnv_bcd;
    logic                 w_snap_load;
    logic                 w_min_capture;
    logic                 w_commit;

    assign w_input_changed = ({bus.minutes, bus.seconds} != {r_snap_min, r_snap_sec});

    // ------------------------------------------------------------------
    // Conversion FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // S_SEC leaves one shift early: the last seconds shift happens on the
    // S_COMMIT edge and is written straight into the display digits.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (w_input_changed) w_state_nxt = S_LOAD;
            S_LOAD:   w_state_nxt = S_MIN;
            S_MIN:    if (w_cnv_done) w_state_nxt = S_SEC;
            S_SEC:    if (w_cnv_almost) w_state_nxt = S_COMMIT;
            S_COMMIT: w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // The minutes converter is loaded from the live inputs on the same edge
    // that fills the snapshot, so both see the identical value. Seconds are
    // restarted on the edge that finishes minutes, left-aligned in 8 bits.
    always_comb begin
        w_cnv_start   = 1'b0;
        w_cnv_bin     = {r_snap_sec, 2'b00};
        w_cnv_len     = CNV_LEN_W'(SEC_W);
        w_snap_load   = 1'b0;
        w_min_capture = 1'b0;
        w_commit      = 1'b0;
        case (r_state)
            S_LOAD: begin
                w_cnv_start = 1'b1;
                w_cnv_bin   = bus.minutes;
                w_cnv_len   = CNV_LEN_W'(MIN_W);
                w_snap_load = 1'b1;
            end
            S_MIN: begin
                if (w_cnv_done) begin
                    w_cnv_start   = 1'b1;
                    w_min_capture = 1'b1;
                end
            end
            S_COMMIT: w_commit = 1'b1;
            default: ;
        endcase
    end

    bin2bcd_serial #(
        .WIDTH (MIN_W)
    ) u_bin2bcd (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (w_cnv_start),
        .len         (w_cnv_len),
        .bin         (w_cnv_bin),
        .done        (w_cnv_done),
        .almost_done (w_cnv_almost),
        .bcd_next    (w_cnv_bcd)
    );

    // ------------------------------------------------------------------
    // Snapshot, intermediate minutes BCD, committed digits
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_snap_min  <= '0;
            r_snap_sec  <= '0;
            r_min_bcd   <= '0;
            r_sec_units <= '0;
            r_sec_tens  <= '0;
            r_min_units <= '0;
            r_min_tens  <= '0;
            r_ovf       <= 1'b0;
        end else begin
            if (w_snap_load) begin
                r_snap_min <= bus.minutes;
                r_snap_sec <= bus.seconds;
            end
            if (w_min_capture) begin
                r_min_bcd <= w_cnv_bcd;
            end
            if (w_commit) begin
                r_sec_units <= w_cnv_bcd[3:0];
                r_sec_tens  <= w_cnv_bcd[7:4];
                r_min_units <= r_min_bcd[3:0];
                r_min_tens  <= r_min_bcd[7:4];
                r_ovf       <= (r_min_bcd[11:8] != 4'd0);
            end
        end
    end

    // ------------------------------------------------------------------
    // Digit scan, free-running and independent of the converter
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ref <= '0;
            r_idx <= 2'd0;
        end else if (r_ref == REF_W'(REFRESH_DIV - 1)) begin
            r_ref <= '0;
            r_idx <= r_idx + 2'd1;
        end else begin
            r_ref <= r_ref + REF_W'(1);
        end
    end

    always_comb begin
        w_digit = r_sec_units;
        case (r_idx)
            DIG_SEC_UNITS: w_digit = r_sec_units;
            DIG_SEC_TENS:  w_digit = r_sec_tens;
            DIG_MIN_UNITS: w_digit = r_min_units;
            DIG_MIN_TENS:  w_digit = r_min_tens;
            default:       w_digit = r_sec_units;
        endcase
    end

    // ------------------------------------------------------------------
    // Optional pause blink
    // ------------------------------------------------------------------
`ifdef DISPLAY_BLINK_EN
    localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    logic [BLINK_W-1:0] r_blink_cnt;
    logic               r_phase;

    // Held at zero outside PAUSED so a fresh pause starts visible
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_blink_cnt <= '0;
            r_phase     <= 1'b0;
        end else if (bus.status != ST_PAUSED) begin
            r_blink_cnt <= '0;
            r_phase     <= 1'b0;
        end else if (r_blink_cnt == BLINK_W'(BLINK_DIV - 1)) begin
            r_blink_cnt <= '0;
            r_phase     <= ~r_phase;
        end else begin
            r_blink_cnt <= r_blink_cnt + BLINK_W'(1);
        end
    end

    assign w_blank = (bus.status == ST_PAUSED) && r_phase;
`else
    logic w_unused_cfg;

    assign w_blank      = 1'b0;
    assign w_unused_cfg = (^bus.status) ^ BLINK_DIV[0];
`endif

    // ------------------------------------------------------------------
    // Registered display outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an_n    <= 4'b1111;
            seg_n   <= SEG_BLANK;
            dp_n    <= 1'b1;
            min_ovf <= 1'b0;
        end else begin
            an_n    <= w_blank ? 4'b1111 : ~(4'b0001 << r_idx);
            seg_n   <= seg_encode(w_digit);
            dp_n    <= (r_idx != DIG_MIN_UNITS);
            min_ovf <= r_ovf;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_stopwatch_display.sv
`default_nettype none
// ============================================================================
//  Module      : tb_stopwatch_display
//  Description : Self-checking bench for stopwatch_display. A reference
//                model predicts every registered output frame from the
//                display rules (edge count, decimal arithmetic, conversion
//                latency) and queues it; a monitor pops and compares one
//                frame per cycle on the falling edge.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_stopwatch_display;

    localparam int REFRESH_DIV = 4;
    localparam int BLINK_DIV   = 8;
    localparam int LATENCY     = 16;

    localparam logic [6:0] SEG_REF [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                           7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       ovf;
    } frame_t;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] seg_n;
    logic       dp_n;
    logic [3:0] an_n;
    logic       min_ovf;

    int n_cmp = 0;
    int n_err = 0;

    frame_t exp_q[$];

    stopwatch_display_if bus ();

    stopwatch_display #(
        .REFRESH_DIV (REFRESH_DIV),
        .BLINK_DIV   (BLINK_DIV)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .seg_n   (seg_n),
        .dp_n    (dp_n),
        .an_n    (an_n),
        .min_ovf (min_ovf)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, n_cmp=%0d", n_cmp);
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Reference model: what the outputs must hold after each rising edge
    // ------------------------------------------------------------------
    int     m_edge;      // edges since reset release
    int     m_conv;      // 0 = waiting, else edges into current conversion
    int     m_snap_min, m_snap_sec;
    int     m_com_min,  m_com_sec;
    int     m_pause_run;
    int     m_idx, m_dig;
    frame_t m_f;

    initial begin
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                m_edge      = 0;
                m_conv      = 0;
                m_snap_min  = 0;
                m_snap_sec  = 0;
                m_com_min   = 0;
                m_com_sec   = 0;
                m_pause_run = 0;
            end else begin
                m_edge = m_edge + 1;
                m_idx  = ((m_edge - 1) / REFRESH_DIV) % 4;
                case (m_idx)
                    0:       m_dig = m_com_sec % 10;
                    1:       m_dig = m_com_sec / 10;
                    2:       m_dig = m_com_min % 10;
                    default: m_dig = (m_com_min / 10) % 10;
                endcase
                m_f.an  = ~(4'b0001 << m_idx);
                m_f.seg = SEG_REF[m_dig];
                m_f.dp  = (m_idx != 2);
                m_f.ovf = (m_com_min >= 100);
`ifdef DISPLAY_BLINK_EN
                if (bus.status == 2'b10) begin
                    if (((m_pause_run / BLINK_DIV) % 2) == 1) m_f.an = 4'b1111;
                    m_pause_run = m_pause_run + 1;
                end else begin
                    m_pause_run = 0;
                end
`endif
                exp_q.push_back(m_f);

                // Conversion timeline: detect edge = 1, inputs latched on
                // edge 2, digits committed on edge LATENCY.
                if (m_conv == 0) begin
                    if (int'(bus.minutes) != m_snap_min || int'(bus.seconds) != m_snap_sec)
                        m_conv = 1;
                end else begin
                    m_conv = m_conv + 1;
                    if (m_conv == 2) begin
                        m_snap_min = int'(bus.minutes);
                        m_snap_sec = int'(bus.seconds);
                    end
                    if (m_conv == LATENCY) begin
                        m_com_min = m_snap_min;
                        m_com_sec = m_snap_sec;
                        m_conv    = 0;
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Monitor: one output frame per cycle
    // ------------------------------------------------------------------
    frame_t mon_got, mon_exp;

    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                mon_exp = exp_q.pop_front();
                mon_got = '{an: an_n, seg: seg_n, dp: dp_n, ovf: min_ovf};
                n_cmp   = n_cmp + 1;
                if (mon_got !== mon_exp) begin
                    n_err = n_err + 1;
                    $display("FAIL scan_frame t=%0t got an_n=%b seg_n=%b dp_n=%b min_ovf=%b want an_n=%b seg_n=%b dp_n=%b min_ovf=%b",
                             $time, mon_got.an, mon_got.seg, mon_got.dp, mon_got.ovf,
                             mon_exp.an, mon_exp.seg, mon_exp.dp, mon_exp.ovf);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    task automatic check_reset(input string name);
        n_cmp = n_cmp + 1;
        if ({an_n, seg_n, dp_n, min_ovf} !== {4'b1111, 7'h7F, 1'b1, 1'b0}) begin
            n_err = n_err + 1;
            $display("FAIL %s got an_n=%b seg_n=%h dp_n=%b min_ovf=%b want an_n=1111 seg_n=7f dp_n=1 min_ovf=0",
                     name, an_n, seg_n, dp_n, min_ovf);
        end
    endtask

    task automatic hold(input int mins, input int secs, input int st, input int cycles);
        @(negedge clk);
        bus.minutes = 8'(mins);
        bus.seconds = 6'(secs);
        bus.status  = 2'(st);
        repeat (cycles - 1) @(negedge clk);
    endtask

    initial begin
        bus.minutes = 8'd0;
        bus.seconds = 6'd0;
        bus.status  = 2'b00;
        rst_n       = 1'b0;
        repeat (3) @(negedge clk);
        #1 check_reset("reset_initial");
        #1 rst_n = 1'b1;

        // Directed cases
        hold(59, 59, 1, 40);
        hold(123, 7, 1, 40);
        hold(99, 7, 1, 40);
        hold(3, 7, 1, 3);          // change to 4 arrives mid-conversion
        hold(4, 7, 1, 45);
        hold(0, 0, 1, 5);
        hold(255, 59, 1, 40);
        hold(100, 0, 1, 40);

        // Reset while the minutes conversion is in progress
        hold(200, 33, 1, 1);
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset("reset_mid_conversion");
        repeat (3) @(negedge clk);
        #1 check_reset("reset_held");
        #1 rst_n = 1'b1;
        hold(200, 33, 1, 40);

        // Pause blink, then steady run
        hold(45, 30, 2, 40);
        hold(45, 30, 1, 20);
        hold(12, 34, 2, 20);
        hold(12, 34, 0, 20);

        // Randomized traffic
        repeat (150) begin
            hold(int'($urandom_range(255)), int'($urandom_range(59)),
                 int'($urandom_range(2)), int'($urandom_range(40, 1)));
        end

        repeat (40) @(negedge clk);
        #3;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
